// File: rtl/alu_reservation_station_pkg.sv
// Shared widths, opcodes and entry layout for the ALU reservation station.
package alu_reservation_station_pkg;

  localparam int DATA_W      = 32;
  localparam int OPC_W       = 6;
  localparam int ROB_TAG_W   = 5;
  localparam int RS_SIZE_DEF = 16;
  localparam int RS_IDX_W_DEF = 4;

  localparam logic [DATA_W-1:0]    ZERO_DATA    = '0;
  localparam logic [ROB_TAG_W-1:0] ZERO_TAG_ROB = '0;

  // Internal opcodes; NOP doubles as "nothing issued" on the output port.
  localparam logic [OPC_W-1:0] OP_NOP   = 6'd0;
  localparam logic [OPC_W-1:0] OP_ADD   = 6'd1;
  localparam logic [OPC_W-1:0] OP_SUB   = 6'd2;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'd3;
  localparam logic [OPC_W-1:0] OP_AND   = 6'd4;
  localparam logic [OPC_W-1:0] OP_OR    = 6'd5;
  localparam logic [OPC_W-1:0] OP_LUI   = 6'd6;
  localparam logic [OPC_W-1:0] OP_AUIPC = 6'd7;
  localparam logic [OPC_W-1:0] OP_JAL   = 6'd8;
  localparam logic [OPC_W-1:0] OP_JALR  = 6'd9;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'd10;

  // An operand is either a valid value (tag == 0) or a pending ROB tag.
  typedef struct packed {
    logic [DATA_W-1:0]    value;
    logic [ROB_TAG_W-1:0] tag;
  } operand_t;

  typedef struct packed {
    logic [OPC_W-1:0]     op;
    operand_t             src1;
    operand_t             src2;
    logic [DATA_W-1:0]    imm;
    logic [DATA_W-1:0]    pc;
    logic [ROB_TAG_W-1:0] robTag;
  } rs_entry_t;

  // Snoop both result buses for a pending operand. A pending tag is never
  // zero, so a match implies a live broadcast; the ALU bus wins a tie.
  function automatic operand_t captureOperand(
    input operand_t             cur,
    input logic [ROB_TAG_W-1:0] aluTag,
    input logic [DATA_W-1:0]    aluValue,
    input logic [ROB_TAG_W-1:0] lsbTag,
    input logic [DATA_W-1:0]    lsbValue
  );
    operand_t res;
    res = cur;
    if (cur.tag != ZERO_TAG_ROB) begin
      if (cur.tag == aluTag) begin
        res.value = aluValue;
        res.tag   = ZERO_TAG_ROB;
      end else if (cur.tag == lsbTag) begin
        res.value = lsbValue;
        res.tag   = ZERO_TAG_ROB;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_reservation_station_rs_find_first.sv
// Lowest-set-bit encoder with a found flag; used for free and ready slot search.
module rs_find_first #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// Reservation station for ALU-class instructions: buffers dispatched entries,
// wakes operands from the ALU/LSB result buses, issues one ready entry per cycle.
module alu_reservation_station
  import alu_reservation_station_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEF,
  parameter int IDX_W   = RS_IDX_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 in_rob_flush,
  input  logic                 in_disp_en,
  input  logic [OPC_W-1:0]     in_op,
  input  logic [DATA_W-1:0]    in_value1,
  input  logic [DATA_W-1:0]    in_value2,
  input  logic [ROB_TAG_W-1:0] in_tag1,
  input  logic [ROB_TAG_W-1:0] in_tag2,
  input  logic [DATA_W-1:0]    in_imm,
  input  logic [DATA_W-1:0]    in_pc,
  input  logic [ROB_TAG_W-1:0] in_rob_tag,
  input  logic [ROB_TAG_W-1:0] in_alu_cdb_tag,
  input  logic [DATA_W-1:0]    in_alu_cdb_value,
  input  logic [ROB_TAG_W-1:0] in_lsb_cdb_tag,
  input  logic [DATA_W-1:0]    in_lsb_cdb_value,
  output logic                 out_full,
  output logic [OPC_W-1:0]     out_op,
  output logic [DATA_W-1:0]    out_value1,
  output logic [DATA_W-1:0]    out_value2,
  output logic [DATA_W-1:0]    out_imm,
  output logic [DATA_W-1:0]    out_pc,
  output logic [ROB_TAG_W-1:0] out_rob_tag
);

  logic [RS_SIZE-1:0] busy_q, busy_d;
  rs_entry_t          entry_q [RS_SIZE];
  rs_entry_t          entry_d [RS_SIZE];

  logic [OPC_W-1:0]     outOp_q;
  logic [DATA_W-1:0]    outValue1_q, outValue2_q, outImm_q, outPc_q;
  logic [ROB_TAG_W-1:0] outRobTag_q;

  logic [RS_SIZE-1:0] readyVec;
  logic [IDX_W-1:0]   freeIdx, selIdx;
  logic               freeFound, selFound;
  rs_entry_t          newEntry;

  // Readiness is taken from registered state only, so anything written or
  // woken this cycle waits at least one more edge before it can issue.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      readyVec[i] = busy_q[i] && (entry_q[i].src1.tag == ZERO_TAG_ROB)
                              && (entry_q[i].src2.tag == ZERO_TAG_ROB);
    end
  end

  rs_find_first #(.N(RS_SIZE), .IDX_W(IDX_W)) uFreeSearch (
    .req_i  (~busy_q),
    .idx_o  (freeIdx),
    .found_o(freeFound)
  );

  rs_find_first #(.N(RS_SIZE), .IDX_W(IDX_W)) uReadySearch (
    .req_i  (readyVec),
    .idx_o  (selIdx),
    .found_o(selFound)
  );

  // Build the incoming entry, forwarding any result broadcast in the same cycle.
  always_comb begin
    newEntry        = '0;
    newEntry.op     = in_op;
    newEntry.imm    = in_imm;
    newEntry.pc     = in_pc;
    newEntry.robTag = in_rob_tag;
    newEntry.src1   = captureOperand('{value: in_value1, tag: in_tag1},
                                     in_alu_cdb_tag, in_alu_cdb_value,
                                     in_lsb_cdb_tag, in_lsb_cdb_value);
    newEntry.src2   = captureOperand('{value: in_value2, tag: in_tag2},
                                     in_alu_cdb_tag, in_alu_cdb_value,
                                     in_lsb_cdb_tag, in_lsb_cdb_value);
  end

  // Next state: wake pending operands, retire the issued slot, then place the
  // dispatch in the lowest free slot. The issued slot is still busy in busy_q,
  // so the free search can never hand it to the dispatch in the same cycle.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      entry_d[i] = entry_q[i];
      if (busy_q[i]) begin
        entry_d[i].src1 = captureOperand(entry_q[i].src1,
                                         in_alu_cdb_tag, in_alu_cdb_value,
                                         in_lsb_cdb_tag, in_lsb_cdb_value);
        entry_d[i].src2 = captureOperand(entry_q[i].src2,
                                         in_alu_cdb_tag, in_alu_cdb_value,
                                         in_lsb_cdb_tag, in_lsb_cdb_value);
      end
    end
    if (selFound) begin
      busy_d[selIdx] = 1'b0;
    end
    if (in_disp_en && freeFound) begin
      busy_d[freeIdx]  = 1'b1;
      entry_d[freeIdx] = newEntry;
    end
  end

  // Entry storage; only the busy bits need clearing on reset or flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else if (rdy) begin
      if (in_rob_flush) begin
        busy_q <= '0;
      end else begin
        busy_q <= busy_d;
        for (int i = 0; i < RS_SIZE; i++) begin
          entry_q[i] <= entry_d[i];
        end
      end
    end
  end

  // Registered issue port; operands only change when something issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      outOp_q     <= OP_NOP;
      outRobTag_q <= ZERO_TAG_ROB;
      outValue1_q <= ZERO_DATA;
      outValue2_q <= ZERO_DATA;
      outImm_q    <= ZERO_DATA;
      outPc_q     <= ZERO_DATA;
    end else if (rdy) begin
      if (in_rob_flush || !selFound) begin
        outOp_q     <= OP_NOP;
        outRobTag_q <= ZERO_TAG_ROB;
      end else begin
        outOp_q     <= entry_q[selIdx].op;
        outRobTag_q <= entry_q[selIdx].robTag;
        outValue1_q <= entry_q[selIdx].src1.value;
        outValue2_q <= entry_q[selIdx].src2.value;
        outImm_q    <= entry_q[selIdx].imm;
        outPc_q     <= entry_q[selIdx].pc;
      end
    end
  end

  // The dispatcher must respect out_full; a dispatch into a full station is dropped.
  always_ff @(posedge clk) begin
    if (!rst && rdy && !in_rob_flush) begin
      assert (!(in_disp_en && out_full));
    end
  end

  assign out_full    = &busy_q;
  assign out_op      = outOp_q;
  assign out_rob_tag = outRobTag_q;
  assign out_value1  = outValue1_q;
  assign out_value2  = outValue2_q;
  assign out_imm     = outImm_q;
  assign out_pc      = outPc_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed self-checking bench for the ALU reservation station.
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst, rdy, in_rob_flush, in_disp_en;
  logic [OPC_W-1:0]     in_op;
  logic [DATA_W-1:0]    in_value1, in_value2, in_imm, in_pc;
  logic [ROB_TAG_W-1:0] in_tag1, in_tag2, in_rob_tag;
  logic [ROB_TAG_W-1:0] in_alu_cdb_tag, in_lsb_cdb_tag;
  logic [DATA_W-1:0]    in_alu_cdb_value, in_lsb_cdb_value;
  logic                 out_full;
  logic [OPC_W-1:0]     out_op;
  logic [DATA_W-1:0]    out_value1, out_value2, out_imm, out_pc;
  logic [ROB_TAG_W-1:0] out_rob_tag;

  int vectorCount = 0;
  int missCount   = 0;

  alu_reservation_station dut (
    .clk(clk), .rst(rst), .rdy(rdy), .in_rob_flush(in_rob_flush),
    .in_disp_en(in_disp_en), .in_op(in_op),
    .in_value1(in_value1), .in_value2(in_value2),
    .in_tag1(in_tag1), .in_tag2(in_tag2),
    .in_imm(in_imm), .in_pc(in_pc), .in_rob_tag(in_rob_tag),
    .in_alu_cdb_tag(in_alu_cdb_tag), .in_alu_cdb_value(in_alu_cdb_value),
    .in_lsb_cdb_tag(in_lsb_cdb_tag), .in_lsb_cdb_value(in_lsb_cdb_value),
    .out_full(out_full), .out_op(out_op),
    .out_value1(out_value1), .out_value2(out_value2),
    .out_imm(out_imm), .out_pc(out_pc), .out_rob_tag(out_rob_tag)
  );

  always #5 clk = ~clk;

  // Safety net in case the run ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [OPC_W-1:0] op,
                               input logic [31:0] v1, input logic [ROB_TAG_W-1:0] t1,
                               input logic [31:0] v2, input logic [ROB_TAG_W-1:0] t2,
                               input logic [31:0] imm, input logic [31:0] pc,
                               input logic [ROB_TAG_W-1:0] rob);
    in_disp_en = 1'b1;
    in_op      = op;
    in_value1  = v1;
    in_tag1    = t1;
    in_value2  = v2;
    in_tag2    = t2;
    in_imm     = imm;
    in_pc      = pc;
    in_rob_tag = rob;
  endtask

  task automatic idle();
    in_disp_en       = 1'b0;
    in_op            = OP_NOP;
    in_alu_cdb_tag   = '0;
    in_alu_cdb_value = '0;
    in_lsb_cdb_tag   = '0;
    in_lsb_cdb_value = '0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; in_rob_flush = 1'b0;
    in_value1 = '0; in_value2 = '0; in_tag1 = '0; in_tag2 = '0;
    in_imm = '0; in_pc = '0; in_rob_tag = '0;
    idle();

    // Reset
    tick();
    rst = 1'b0;
    checkOutput("reset_op", 32'(out_op), 32'(OP_NOP));
    checkOutput("reset_rob", 32'(out_rob_tag), 32'd0);
    checkOutput("reset_full", 32'(out_full), 32'd0);
    checkOutput("reset_v1", out_value1, 32'd0);

    // Ready dispatch: written at edge 0, issued at edge 1
    applyStimulus(OP_ADDI, 32'd5, 5'd0, 32'd0, 5'd0, 32'd3, 32'h100, 5'd2);
    tick();
    idle();
    checkOutput("rdy_disp_not_yet", 32'(out_op), 32'(OP_NOP));
    tick();
    checkOutput("rdy_disp_op", 32'(out_op), 32'(OP_ADDI));
    checkOutput("rdy_disp_v1", out_value1, 32'd5);
    checkOutput("rdy_disp_imm", out_imm, 32'd3);
    checkOutput("rdy_disp_pc", out_pc, 32'h100);
    checkOutput("rdy_disp_rob", 32'(out_rob_tag), 32'd2);
    tick();
    checkOutput("rdy_disp_after_op", 32'(out_op), 32'(OP_NOP));
    checkOutput("rdy_disp_after_rob", 32'(out_rob_tag), 32'd0);

    // Wakeup from the ALU bus two cycles after dispatch
    applyStimulus(OP_ADD, 32'd0, 5'd3, 32'd1, 5'd0, 32'd0, 32'h104, 5'd6);
    tick();
    idle();
    tick();
    checkOutput("wake_waiting", 32'(out_op), 32'(OP_NOP));
    in_alu_cdb_tag = 5'd3; in_alu_cdb_value = 32'h10;
    tick();
    idle();
    checkOutput("wake_not_yet", 32'(out_op), 32'(OP_NOP));
    tick();
    checkOutput("wake_op", 32'(out_op), 32'(OP_ADD));
    checkOutput("wake_v1", out_value1, 32'h10);
    checkOutput("wake_v2", out_value2, 32'd1);
    checkOutput("wake_rob", 32'(out_rob_tag), 32'd6);

    // Same-cycle forwarding from the LSB bus
    applyStimulus(OP_SUB, 32'd9, 5'd0, 32'd0, 5'd4, 32'd0, 32'h200, 5'd7);
    in_lsb_cdb_tag = 5'd4; in_lsb_cdb_value = 32'd7;
    tick();
    idle();
    tick();
    checkOutput("fwd_op", 32'(out_op), 32'(OP_SUB));
    checkOutput("fwd_v1", out_value1, 32'd9);
    checkOutput("fwd_v2", out_value2, 32'd7);
    checkOutput("fwd_rob", 32'(out_rob_tag), 32'd7);

    // Both buses carry the same tag at dispatch: ALU value must win
    applyStimulus(OP_AND, 32'd0, 5'd8, 32'h33, 5'd0, 32'd0, 32'h204, 5'd8);
    in_alu_cdb_tag = 5'd8; in_alu_cdb_value = 32'hAA;
    in_lsb_cdb_tag = 5'd8; in_lsb_cdb_value = 32'hBB;
    tick();
    idle();
    tick();
    checkOutput("prec_v1", out_value1, 32'hAA);
    checkOutput("prec_rob", 32'(out_rob_tag), 32'd8);

    // Both stored operands wake in the same cycle from different buses
    applyStimulus(OP_OR, 32'd0, 5'd11, 32'd0, 5'd12, 32'd0, 32'h208, 5'd9);
    tick();
    idle();
    in_alu_cdb_tag = 5'd11; in_alu_cdb_value = 32'h11;
    in_lsb_cdb_tag = 5'd12; in_lsb_cdb_value = 32'h12;
    tick();
    idle();
    tick();
    checkOutput("dual_op", 32'(out_op), 32'(OP_OR));
    checkOutput("dual_v1", out_value1, 32'h11);
    checkOutput("dual_v2", out_value2, 32'h12);
    checkOutput("dual_rob", 32'(out_rob_tag), 32'd9);

    // Fill every slot with entries waiting on tag 5
    for (int i = 0; i < RS_SIZE_DEF; i++) begin
      applyStimulus(OP_ADD, 32'd0, 5'd5, 32'(i), 5'd0, 32'd0, 32'd0, 5'(i + 1));
      tick();
      if (i == RS_SIZE_DEF - 2) checkOutput("full_almost", 32'(out_full), 32'd0);
    end
    idle();
    checkOutput("full_set", 32'(out_full), 32'd1);
    in_alu_cdb_tag = 5'd5; in_alu_cdb_value = 32'h55;
    tick();
    idle();
    checkOutput("full_after_wake", 32'(out_full), 32'd1);
    checkOutput("full_wake_noissue", 32'(out_op), 32'(OP_NOP));
    tick();
    checkOutput("full_first_rob", 32'(out_rob_tag), 32'd1);
    checkOutput("full_first_v1", out_value1, 32'h55);
    checkOutput("full_first_v2", out_value2, 32'd0);
    checkOutput("full_dropped", 32'(out_full), 32'd0);
    for (int k = 1; k < RS_SIZE_DEF; k++) begin
      tick();
      checkOutput("full_order_rob", 32'(out_rob_tag), 32'(k + 1));
      checkOutput("full_order_v2", out_value2, 32'(k));
    end
    tick();
    checkOutput("full_drained", 32'(out_op), 32'(OP_NOP));

    // Three waiting entries plus one ready issue, then freeze and flush
    for (int i = 0; i < 3; i++) begin
      applyStimulus(OP_ADD, 32'd0, 5'd9, 32'd0, 5'd0, 32'd0, 32'd0, 5'(20 + i));
      tick();
    end
    applyStimulus(OP_ADDI, 32'd42, 5'd0, 32'd0, 5'd0, 32'd1, 32'h300, 5'd23);
    tick();
    idle();
    tick();
    checkOutput("pre_freeze_rob", 32'(out_rob_tag), 32'd23);
    rdy = 1'b0;
    in_alu_cdb_tag = 5'd9; in_alu_cdb_value = 32'h99;
    applyStimulus(OP_ADDI, 32'd1, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd24);
    for (int c = 0; c < 2; c++) begin
      tick();
      checkOutput("freeze_op", 32'(out_op), 32'(OP_ADDI));
      checkOutput("freeze_rob", 32'(out_rob_tag), 32'd23);
      checkOutput("freeze_v1", out_value1, 32'd42);
    end
    rdy = 1'b1;
    idle();
    in_rob_flush = 1'b1;
    tick();
    in_rob_flush = 1'b0;
    checkOutput("flush_op", 32'(out_op), 32'(OP_NOP));
    checkOutput("flush_rob", 32'(out_rob_tag), 32'd0);
    in_alu_cdb_tag = 5'd9; in_alu_cdb_value = 32'h99;
    tick();
    idle();
    tick();
    checkOutput("flush_stale_op", 32'(out_op), 32'(OP_NOP));
    tick();
    checkOutput("flush_stale_rob", 32'(out_rob_tag), 32'd0);

    // Reset mid-operation discards a waiting entry
    applyStimulus(OP_SUB, 32'd0, 5'd10, 32'd0, 5'd0, 32'd0, 32'd0, 5'd3);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_alu_cdb_tag = 5'd10; in_alu_cdb_value = 32'h1;
    tick();
    idle();
    tick();
    checkOutput("rst_mid_op", 32'(out_op), 32'(OP_NOP));
    checkOutput("rst_mid_full", 32'(out_full), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
